prod_accumulator: RTL and testbench



---
 rtl/prod_accumulator_pkg.sv | 13 +
 rtl/prod_accumulator_if.sv | 25 ++
 rtl/prod_accumulator.sv | 79 +++++++
 tb/tb_prod_accumulator.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/prod_accumulator_pkg.sv
// Shared types and constants for the product accumulator stage.
// The stage sits downstream of the 4x4 array multiplier.
package prod_accum_pkg;

    localparam int unsigned PROD_W = 8;
    localparam int unsigned TERM_W = 8;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/prod_accumulator_if.sv
// Input-product and output-sum valid/ready handshakes of the accumulator.
// The slave modport is the accumulator side; the master modport is the producer/consumer side.
interface prod_accumulator_if #(
    parameter int unsigned ACC_W = 12
);
    import prod_accum_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;

    modport slave (
        input  in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_sum
    );

    modport master (
        output in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_sum
    );

endinterface

// File: rtl/prod_accumulator.sv
// Sums batches of N_TERMS multiplier products and holds each finished sum
// on a valid/ready handshake until the consumer takes it.
module prod_accumulator
    import prod_accum_pkg::*;
#(
    parameter int unsigned N_TERMS = 4,
    parameter int unsigned ACC_W   = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    prod_accumulator_if.slave      bus,
    output logic [TERM_W-1:0]      term_cnt,
    output logic [7:0]             result_idx,
    output logic                   ovf
);

    if (N_TERMS < 1 || N_TERMS > 255) begin : g_bad_n_terms
        $error("prod_accumulator: N_TERMS must be in 1..255");
    end
    if (ACC_W < PROD_W) begin : g_bad_acc_w
        $error("prod_accumulator: ACC_W must be at least 8");
    end

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum_q;
    logic [ACC_W:0]   acc_next;
    logic             in_acc;
    logic             out_acc;
    logic             last_term;

    // Handshake outputs are decoded from the state register only.
    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_sum   = sum_q;

    assign in_acc    = bus.in_valid && (state == ACCUM);
    assign out_acc   = bus.out_ready && (state == HOLD);
    assign last_term = (term_cnt == TERM_W'(N_TERMS - 1));
    assign acc_next  = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.in_prod};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACCUM;
            acc        <= '0;
            term_cnt   <= '0;
            sum_q      <= '0;
            result_idx <= '0;
            ovf        <= 1'b0;
        end else if (clear) begin
            // Held result is discarded; sum_q keeps its last value.
            state    <= ACCUM;
            acc      <= '0;
            term_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            if (in_acc) begin
                if (acc_next[ACC_W]) begin
                    ovf <= 1'b1;
                end
                if (last_term) begin
                    sum_q    <= acc_next[ACC_W-1:0];
                    acc      <= '0;
                    term_cnt <= '0;
                    state    <= HOLD;
                end else begin
                    acc      <= acc_next[ACC_W-1:0];
                    term_cnt <= term_cnt + 1'b1;
                end
            end
            if (out_acc) begin
                result_idx <= result_idx + 1'b1;
                state      <= ACCUM;
            end
        end
    end

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed-vector bench for prod_accumulator: default build plus an ACC_W=8 build for overflow.
module tb_prod_accumulator;
    import prod_accum_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic clear_a, clear_b;
    logic [7:0] term_cnt_a, term_cnt_b;
    logic [7:0] result_idx_a, result_idx_b;
    logic ovf_a, ovf_b;

    int n_vec = 0;
    int n_err = 0;

    prod_accumulator_if #(.ACC_W(12)) bus_a ();
    prod_accumulator_if #(.ACC_W(8))  bus_b ();

    prod_accumulator #(.N_TERMS(4), .ACC_W(12)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear_a),
        .bus        (bus_a),
        .term_cnt   (term_cnt_a),
        .result_idx (result_idx_a),
        .ovf        (ovf_a)
    );

    prod_accumulator #(.N_TERMS(4), .ACC_W(8)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear_b),
        .bus        (bus_b),
        .term_cnt   (term_cnt_b),
        .result_idx (result_idx_b),
        .ovf        (ovf_b)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_a = 1'b0;
        clear_b = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.in_prod = '0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_prod = '0; bus_b.out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_term_cnt", term_cnt_a, 0);
        chk("rst_out_valid", bus_a.out_valid, 0);
        chk("rst_in_ready", bus_a.in_ready, 1);
        chk("rst_out_sum", bus_a.out_sum, 0);
        chk("rst_result_idx", result_idx_a, 0);
        chk("rst_ovf", ovf_a, 0);

        // Reset mid-batch after two accepts
        bus_a.in_valid = 1'b1; bus_a.in_prod = 8'd7;
        step(); step();
        chk("mid_term_cnt", term_cnt_a, 2);
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        bus_a.in_valid = 1'b0;
        chk("rst2_term_cnt", term_cnt_a, 0);
        chk("rst2_out_valid", bus_a.out_valid, 0);
        chk("rst2_in_ready", bus_a.in_ready, 1);
        chk("rst2_result_idx", result_idx_a, 0);
        chk("rst2_ovf", ovf_a, 0);

        // Basic batch 225+1+0+100 = 326 with out_ready held high
        bus_a.out_ready = 1'b1;
        bus_a.in_valid = 1'b1;
        bus_a.in_prod = 8'd225; step();
        chk("basic_term1", term_cnt_a, 1);
        bus_a.in_prod = 8'd1;   step();
        bus_a.in_prod = 8'd0;   step();
        chk("basic_term3", term_cnt_a, 3);
        chk("basic_no_valid_yet", bus_a.out_valid, 0);
        bus_a.in_prod = 8'd100; step();
        bus_a.in_valid = 1'b0;
        chk("basic_out_valid", bus_a.out_valid, 1);
        chk("basic_out_sum", bus_a.out_sum, 326);
        chk("basic_in_ready", bus_a.in_ready, 0);
        chk("basic_term_reset", term_cnt_a, 0);
        chk("basic_idx_before", result_idx_a, 0);
        step();
        chk("basic_out_taken", bus_a.out_valid, 0);
        chk("basic_in_ready_back", bus_a.in_ready, 1);
        chk("basic_idx_after", result_idx_a, 1);

        // Backpressure: four 50s then stall 5 cycles with in_valid high
        bus_a.out_ready = 1'b0;
        bus_a.in_valid = 1'b1; bus_a.in_prod = 8'd50;
        step(); step(); step(); step();
        chk("bp_out_valid", bus_a.out_valid, 1);
        chk("bp_out_sum", bus_a.out_sum, 200);
        bus_a.in_prod = 8'd99;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_in_ready", bus_a.in_ready, 0);
            chk("bp_hold_valid", bus_a.out_valid, 1);
            chk("bp_hold_sum", bus_a.out_sum, 200);
            chk("bp_hold_term", term_cnt_a, 0);
        end
        bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
        step();
        chk("bp_idx", result_idx_a, 2);
        chk("bp_bubble_ready", bus_a.in_ready, 1);
        bus_a.out_ready = 1'b0;
        bus_a.in_valid = 1'b1; bus_a.in_prod = 8'd50;
        step(); step(); step(); step();
        bus_a.in_valid = 1'b0;
        chk("bp_next_sum", bus_a.out_sum, 200);
        chk("bp_next_valid", bus_a.out_valid, 1);
        bus_a.out_ready = 1'b1;
        step();
        chk("bp_next_idx", result_idx_a, 3);

        // Gaps: in_valid pattern 1,0,0,1,0,1,1 with value 10
        bus_a.out_ready = 1'b0;
        bus_a.in_prod = 8'd10;
        begin
            logic [6:0] pat;
            logic [7:0] exp_term [7];
            pat = 7'b1101001;
            exp_term = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd0};
            for (int i = 0; i < 7; i++) begin
                bus_a.in_valid = pat[i];
                step();
                chk("gap_term", term_cnt_a, exp_term[i]);
                chk("gap_valid", bus_a.out_valid, (i == 6) ? 1 : 0);
            end
        end
        bus_a.in_valid = 1'b0;
        chk("gap_sum", bus_a.out_sum, 40);
        bus_a.out_ready = 1'b1;
        step();
        chk("gap_idx", result_idx_a, 4);

        // clear with the 3rd product drops it; clear in HOLD discards the result
        bus_a.out_ready = 1'b0;
        bus_a.in_valid = 1'b1; bus_a.in_prod = 8'd5;
        step(); step();
        clear_a = 1'b1;
        step();
        clear_a = 1'b0;
        chk("clr_term", term_cnt_a, 0);
        chk("clr_in_ready", bus_a.in_ready, 1);
        chk("clr_out_valid", bus_a.out_valid, 0);
        step(); step(); step(); step();
        bus_a.in_valid = 1'b0;
        chk("clr_fresh_sum", bus_a.out_sum, 20);
        chk("clr_fresh_valid", bus_a.out_valid, 1);
        clear_a = 1'b1; bus_a.out_ready = 1'b1;
        step();
        clear_a = 1'b0; bus_a.out_ready = 1'b0;
        chk("clr_hold_valid", bus_a.out_valid, 0);
        chk("clr_hold_idx", result_idx_a, 4);
        chk("clr_hold_sum", bus_a.out_sum, 20);
        chk("clr_hold_ready", bus_a.in_ready, 1);
        chk("a_ovf_never", ovf_a, 0);

        // Overflow on ACC_W=8 build: four 100s
        bus_b.in_valid = 1'b1; bus_b.in_prod = 8'd100;
        step(); step();
        chk("ovf_after2", ovf_b, 0);
        step();
        chk("ovf_after3", ovf_b, 1);
        step();
        bus_b.in_valid = 1'b0;
        chk("ovf_sum", bus_b.out_sum, 144);
        chk("ovf_valid", bus_b.out_valid, 1);
        chk("ovf_sticky", ovf_b, 1);
        clear_b = 1'b1;
        step();
        clear_b = 1'b0;
        chk("ovf_cleared", ovf_b, 0);
        chk("ovf_clr_valid", bus_b.out_valid, 0);
        chk("ovf_clr_sum_kept", bus_b.out_sum, 144);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
